// File: rtl/regbank_pkg.sv
// Shared definitions for the multi-port register bank: FSM state encoding.
package regbank_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/regbank_mem.sv
// Register storage with one synchronous write port and two combinational read ports.
module regbank_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  // Contents are deliberately not reset; the owner zeroes them with a sweep.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/regbank_mp.sv
// Register bank with two read ports, one write port with write-through bypass,
// a post-reset clearing sweep and a streaming bulk-load mode.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [AW-1:0]    REGISTER1,
  input  logic [AW-1:0]    REGISTER2,
  output logic [WIDTH-1:0] SR1OUT,
  output logic [WIDTH-1:0] SR2OUT,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] DRIN,
  input  logic             LDREG,
  input  logic             LDSTART,
  input  logic             LDVALID,
  input  logic [WIDTH-1:0] LDDATA,
  output logic             LDREADY,
  output logic             READY
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] rd1, rd2;
  logic             run_wr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A bulk-load request wins over a same-cycle register write, which is dropped.
  assign run_wr = (state_q == RUN) && LDREG && !LDSTART;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = DR;
    mem_wdata = DRIN;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (LDSTART) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (LDREG) begin
          mem_we = 1'b1;
        end
      end
      LOAD: begin
        if (LDVALID) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = LDDATA;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  regbank_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (CLK),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .raddr1 (REGISTER1),
    .raddr2 (REGISTER2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  assign SR1OUT  = (run_wr && (DR == REGISTER1)) ? DRIN : rd1;
  assign SR2OUT  = (run_wr && (DR == REGISTER2)) ? DRIN : rd2;
  assign READY   = (state_q == RUN);
  assign LDREADY = (state_q == LOAD);

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: default 16x8 instance plus a 32x16 instance.
module tb_regbank_mp;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (A)
  logic        a_rst_n, a_ldreg, a_ldstart, a_ldvalid, a_ldready, a_ready;
  logic [2:0]  a_r1, a_r2, a_dr;
  logic [15:0] a_sr1, a_sr2, a_drin, a_lddata;

  regbank_mp u_a (
    .CLK(clk), .RST_N(a_rst_n), .REGISTER1(a_r1), .REGISTER2(a_r2),
    .SR1OUT(a_sr1), .SR2OUT(a_sr2), .DR(a_dr), .DRIN(a_drin), .LDREG(a_ldreg),
    .LDSTART(a_ldstart), .LDVALID(a_ldvalid), .LDDATA(a_lddata),
    .LDREADY(a_ldready), .READY(a_ready)
  );

  // Wide/deep instance (B)
  logic        b_rst_n, b_ldreg, b_ldstart, b_ldvalid, b_ldready, b_ready;
  logic [3:0]  b_r1, b_r2, b_dr;
  logic [31:0] b_sr1, b_sr2, b_drin, b_lddata;

  regbank_mp #(.WIDTH(32), .DEPTH(16)) u_b (
    .CLK(clk), .RST_N(b_rst_n), .REGISTER1(b_r1), .REGISTER2(b_r2),
    .SR1OUT(b_sr1), .SR2OUT(b_sr2), .DR(b_dr), .DRIN(b_drin), .LDREG(b_ldreg),
    .LDSTART(b_ldstart), .LDVALID(b_ldvalid), .LDDATA(b_lddata),
    .LDREADY(b_ldready), .READY(b_ready)
  );

  typedef struct {
    logic        ldreg;
    logic [2:0]  dr;
    logic [15:0] drin;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vec [7];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_ready(output int cycles);
    cycles = 0;
    while (a_ready !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic wait_b_ready(output int cycles);
    cycles = 0;
    while (b_ready !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int k;

    vec[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF};
    vec[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'hBEEF, 16'h0000};
    vec[2] = '{1'b1, 3'd7, 16'h1111, 3'd7, 3'd3, 16'h1111, 16'hBEEF};
    vec[3] = '{1'b1, 3'd0, 16'h2222, 3'd3, 3'd0, 16'hBEEF, 16'h2222};
    vec[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h2222, 16'h1111};
    vec[5] = '{1'b1, 3'd3, 16'h3333, 3'd5, 3'd6, 16'h0000, 16'h0000};
    vec[6] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'h3333, 16'h3333};

    a_rst_n = 0; a_ldreg = 0; a_ldstart = 0; a_ldvalid = 0;
    a_r1 = 0; a_r2 = 0; a_dr = 0; a_drin = 0; a_lddata = 0;
    b_rst_n = 0; b_ldreg = 0; b_ldstart = 0; b_ldvalid = 0;
    b_r1 = 0; b_r2 = 0; b_dr = 0; b_drin = 0; b_lddata = 0;

    // Reset state and clear sweep length
    tick(); tick();
    chk("a_reset_ready", 32'(a_ready), 32'd0);
    chk("a_reset_ldready", 32'(a_ldready), 32'd0);
    a_rst_n = 1;
    wait_a_ready(cyc);
    chk("a_clear_cycles", 32'(cyc), 32'd8);
    for (int i = 0; i < 8; i++) begin
      a_r1 = 3'(i); a_r2 = 3'(7 - i);
      #1;
      chk($sformatf("a_clear_rd1_%0d", i), 32'(a_sr1), 32'd0);
      chk($sformatf("a_clear_rd2_%0d", i), 32'(a_sr2), 32'd0);
    end
    tick();

    // RUN-mode writes and bypass, table driven
    for (int i = 0; i < 7; i++) begin
      a_ldreg = vec[i].ldreg; a_dr = vec[i].dr; a_drin = vec[i].drin;
      a_r1 = vec[i].r1; a_r2 = vec[i].r2;
      #1;
      chk($sformatf("vec%0d_sr1", i), 32'(a_sr1), 32'(vec[i].e1));
      chk($sformatf("vec%0d_sr2", i), 32'(a_sr2), 32'(vec[i].e2));
      chk($sformatf("vec%0d_ready", i), 32'(a_ready), 32'd1);
      tick();
    end
    a_ldreg = 0;

    // LDSTART with simultaneous LDREG to register 5
    a_ldstart = 1; a_ldreg = 1; a_dr = 3'd5; a_drin = 16'h1234; a_r1 = 3'd5;
    #1;
    chk("ldstart_ready", 32'(a_ready), 32'd1);
    tick();
    a_ldstart = 0; a_ldreg = 0;
    #1;
    chk("load_ldready", 32'(a_ldready), 32'd1);
    chk("load_ready", 32'(a_ready), 32'd0);
    chk("load_reg5_not_written", 32'(a_sr1), 32'd0);
    // LDREG in LOAD with no beat: ignored and not bypassed
    a_ldreg = 1; a_dr = 3'd5; a_drin = 16'hABCD; a_ldvalid = 0;
    #1;
    chk("load_no_bypass", 32'(a_sr1), 32'd0);
    tick();
    a_ldreg = 0;

    // Eight beats, two-cycle stall after the fourth
    k = 1;
    for (int c = 0; c < 10; c++) begin
      a_ldvalid = (c != 4 && c != 5);
      a_lddata = 16'(k);
      #1;
      chk($sformatf("load_c%0d_ldready", c), 32'(a_ldready), 32'd1);
      if (a_ldvalid) k++;
      tick();
    end
    a_ldvalid = 0;
    chk("load_done_ready", 32'(a_ready), 32'd1);
    chk("load_done_ldready", 32'(a_ldready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      a_r1 = 3'(i); a_r2 = 3'(7 - i);
      #1;
      chk($sformatf("load_rd1_%0d", i), 32'(a_sr1), 32'(i + 1));
      chk($sformatf("load_rd2_%0d", i), 32'(a_sr2), 32'(8 - i));
    end
    tick();

    // Second load restarts at index 0; reset after the 3rd beat
    a_ldstart = 1;
    tick();
    a_ldstart = 0;
    for (int c = 0; c < 3; c++) begin
      a_ldvalid = 1; a_lddata = 16'(16'h10 + c);
      tick();
    end
    a_ldvalid = 0; a_r1 = 3'd0; a_r2 = 3'd2;
    #1;
    chk("reload_rd0", 32'(a_sr1), 32'h10);
    chk("reload_rd2", 32'(a_sr2), 32'h12);
    chk("reload_ldready", 32'(a_ldready), 32'd1);
    a_rst_n = 0;
    #1;
    chk("midload_rst_ldready", 32'(a_ldready), 32'd0);
    chk("midload_rst_ready", 32'(a_ready), 32'd0);
    tick();
    // LDSTART and LDREG held through CLEAR must be ignored
    a_ldstart = 1; a_ldreg = 1; a_dr = 3'd2; a_drin = 16'hFFFF;
    a_rst_n = 1;
    wait_a_ready(cyc);
    a_ldstart = 0; a_ldreg = 0;
    chk("reclear_cycles", 32'(cyc), 32'd8);
    tick();
    chk("reclear_ready", 32'(a_ready), 32'd1);
    chk("reclear_ldready", 32'(a_ldready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      a_r1 = 3'(i); a_r2 = 3'(7 - i);
      #1;
      chk($sformatf("reclear_rd1_%0d", i), 32'(a_sr1), 32'd0);
      chk($sformatf("reclear_rd2_%0d", i), 32'(a_sr2), 32'd0);
    end
    tick();

    // WIDTH=32, DEPTH=16 instance
    b_rst_n = 1;
    wait_b_ready(cyc);
    chk("b_clear_cycles", 32'(cyc), 32'd16);
    b_r1 = 4'd15; b_r2 = 4'd0;
    #1;
    chk("b_clear_rd15", b_sr1, 32'd0);
    chk("b_clear_rd0", b_sr2, 32'd0);
    tick();
    b_ldstart = 1;
    tick();
    b_ldstart = 0;
    chk("b_ldready", 32'(b_ldready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      b_ldvalid = 1; b_lddata = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    b_ldvalid = 0;
    chk("b_load_done_ready", 32'(b_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      b_r1 = 4'(i); b_r2 = 4'(15 - i);
      #1;
      chk($sformatf("b_rd1_%0d", i), b_sr1, 32'hA5A5_0000 + 32'(i));
      chk($sformatf("b_rd2_%0d", i), b_sr2, 32'hA5A5_0000 + 32'(15 - i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
REGBANK_MP -- requirements
Module: regbank_mp

Interface
REQ-001 Parameter WIDTH, default 16: register data width in bits.
REQ-002 Parameter DEPTH, default 8: number of registers; power of two, at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH): width of every register-index port.
REQ-004 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port RST_N, input, 1: reset, asynchronous and active-low.
REQ-006 Port REGISTER1, input, AW: read-port-1 register index.
REQ-007 Port REGISTER2, input, AW: read-port-2 register index.
REQ-008 Port SR1OUT, output, WIDTH: read-port-1 data.
REQ-009 Port SR2OUT, output, WIDTH: read-port-2 data.
REQ-010 Port DR, input, AW: write-port register index.
REQ-011 Port DRIN, input, WIDTH: write-port data.
REQ-012 Port LDREG, input, 1: write enable.
REQ-013 Port LDSTART, input, 1: single-cycle pulse requesting a bulk load.
REQ-014 Port LDVALID, input, 1: bulk-load data beat valid.
REQ-015 Port LDDATA, input, WIDTH: bulk-load data beat.
REQ-016 Port LDREADY, output, 1: bank accepts a bulk-load beat.
REQ-017 Port READY, output, 1: bank is in RUN and accepts LDREG writes.

Function
REQ-018 The FSM SHALL have three states: CLEAR, RUN and LOAD.
REQ-019 CLEAR SHALL zero register CNT each cycle, CNT counting 0 to DEPTH-1, then enter RUN; it SHALL last exactly DEPTH cycles.
REQ-020 In RUN, LDREG=1 SHALL write DRIN to register DR at the clock edge.
REQ-021 In CLEAR and LOAD, LDREG SHALL be ignored.
REQ-022 SR1OUT and SR2OUT SHALL be combinational reads of REGISTER1 and REGISTER2.
REQ-023 In RUN, when LDREG=1 and DR equals the read index, that port SHALL output DRIN in the same cycle (write-through bypass).
REQ-024 Both read ports SHALL bypass independently when both indices match DR.
REQ-025 In RUN, LDSTART=1 SHALL enter LOAD with CNT=0; LDSTART SHALL take priority over a simultaneous LDREG, and that LDREG write SHALL be dropped.
REQ-026 LDSTART SHALL be ignored outside RUN.
REQ-027 In LOAD, LDREADY SHALL be 1, and each cycle with LDVALID=1 SHALL write LDDATA to register CNT and increment CNT.
REQ-028 A LOAD cycle with LDVALID=0 SHALL leave all registers and CNT unchanged; stalls have unlimited length.
REQ-029 The beat written to register DEPTH-1 SHALL return the FSM to RUN on the next cycle, and CNT SHALL wrap to 0.
REQ-030 READY SHALL be 1 only in RUN; LDREADY SHALL be 1 only in LOAD.
REQ-031 Bypass SHALL apply only to LDREG writes; in LOAD, reads SHALL return stored contents.

Reset
REQ-032 RST_N low SHALL immediately force state to CLEAR, CNT to 0, READY to 0 and LDREADY to 0.
REQ-033 Register contents SHALL NOT be reset directly; they SHALL be zeroed by the CLEAR sweep after RST_N rises.
REQ-034 Reset asserted mid-LOAD or mid-CLEAR SHALL abort the operation and restart CLEAR from index 0.
REQ-035 SR1OUT and SR2OUT SHALL read 0 for every index once CLEAR completes.

Structure
REQ-036 The state encoding (CLEAR=2'd0, RUN=2'd1, LOAD=2'd2) SHALL be defined in the shared package regbank_pkg.
REQ-037 The storage array with its two read ports SHALL be the sub-module regbank_mem; the FSM, counter and bypass SHALL live in regbank_mp.

Verification
REQ-038 Release reset with defaults: READY=0 for exactly 8 cycles, then READY=1; every index reads 0.
REQ-039 In RUN, LDREG=1, DR=3, DRIN=16'hBEEF, REGISTER1=REGISTER2=3: SR1OUT=SR2OUT=16'hBEEF in the same cycle, and after the edge with LDREG=0.
REQ-040 LDSTART, then 8 beats 16'h0001 through 16'h0008 with LDVALID deasserted for 2 cycles after beat 4: registers 0 through 7 hold 1 through 8, and READY=1 the cycle after the last beat.
REQ-041 LDSTART and LDREG (DR=5, DRIN=16'h1234) in the same cycle: LOAD is entered and register 5 is not written by the LDREG.
REQ-042 RST_N pulsed low after the 3rd LOAD beat: LDREADY=0 immediately, CLEAR runs 8 cycles, and all registers read 0.
REQ-043 WIDTH=32, DEPTH=16: the CLEAR sweep lasts 16 cycles and a 16-beat LOAD of 32'hA5A5_0000+i reads back correctly on both ports.
